// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: 16-byte register window, byte FIFO feeding
// a baud-rate shifter, with a registered empty-and-idle interrupt.
module uart_tx_port #(
  parameter logic [31:0] BASE_ADDRESS    = 32'hff00_0000,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd433,
  parameter int          FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:2] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic [3:0]  data_strobes,
  input  logic        read,
  input  logic        write,
  output logic        selected,
  output logic        tx,
  output logic        irq
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       overflow, enable, irq_enable;
  logic [15:0]                divisor, baud_cnt;
  logic [1:0]                 state;
  logic [2:0]                 bit_index;
  logic [7:0]                 shift;
  logic [1:0]                 offset;
  logic                       wr_en, push, pop, empty, full, busy, baud_zero, store;
  logic [31:0]                status;
  logic                       unused_bits;

  assign offset    = address[3:2];
  assign selected  = (address[31:4] == BASE_ADDRESS[31:4]);
  assign wr_en     = write & selected;
  assign push      = wr_en && (offset == 2'd0) && data_strobes[0];
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign busy      = (state != ST_IDLE);
  assign pop       = (state == ST_IDLE) && enable && !empty;
  assign baud_zero = (baud_cnt == 16'd0);
  // A push into a full FIFO only lands when a pop frees the slot in the same cycle.
  assign store     = push && (!full || pop);
  assign unused_bits = &{1'b0, data_in[31:16], data_strobes[3:2]};

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      enable     <= 1'b0;
      irq_enable <= 1'b0;
      divisor    <= DEFAULT_DIVISOR;
      state      <= ST_IDLE;
      baud_cnt   <= 16'd0;
      bit_index  <= 3'd0;
      irq        <= 1'b0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop && !full)  count <= count + CNT_W'(1);
      else if (pop && !push)      count <= count - CNT_W'(1);

      if (push && full && !pop)
        overflow <= 1'b0 | 1'b1;
      else if (wr_en && offset == 2'd1 && data_strobes[0] && data_in[3])
        overflow <= 1'b0;

      if (wr_en && offset == 2'd2) begin
        if (data_strobes[0]) divisor[7:0]  <= data_in[7:0];
        if (data_strobes[1]) divisor[15:8] <= data_in[15:8];
      end
      if (wr_en && offset == 2'd3 && data_strobes[0]) begin
        enable     <= data_in[0];
        irq_enable <= data_in[1];
      end

      case (state)
        ST_IDLE: begin
          if (pop) begin
            baud_cnt <= divisor;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (baud_zero) begin
            baud_cnt  <= divisor;
            bit_index <= 3'd0;
            state     <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_zero) begin
            baud_cnt  <= divisor;
            bit_index <= bit_index + 3'd1;
            if (bit_index == 3'd7) state <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          if (baud_zero) state <= ST_IDLE;
          else           baud_cnt <= baud_cnt - 16'd1;
        end
      endcase

      irq <= irq_enable & empty & (state == ST_IDLE);
    end
  end

  // FIFO storage and shift register carry data only; no reset needed.
  always_ff @(posedge clock) begin
    if (store) mem[wr_ptr] <= data_in[7:0];
    if (pop)
      shift <= mem[rd_ptr];
    else if (state == ST_DATA && baud_zero)
      shift <= {1'b0, shift[7:1]};
  end

  always_comb begin
    case (state)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = shift[0];
      default:  tx = 1'b1;
    endcase
  end

  always_comb begin
    status              = '0;
    status[0]           = empty;
    status[1]           = full;
    status[2]           = busy;
    status[3]           = overflow;
    status[8 +: CNT_W]  = count;
  end

  always_comb begin
    data_out = 32'h0;
    if (read && selected) begin
      case (offset)
        2'd1:    data_out = status;
        2'd2:    data_out = {16'h0, divisor};
        2'd3:    data_out = {30'h0, irq_enable, enable};
        default: data_out = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed self-checking bench for uart_tx_port: one task per scenario, inline checks.
module tb_uart_tx_port;

  localparam logic [31:0] BASE = 32'hff00_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:2] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [3:0]  data_strobes;
  logic        read;
  logic        write;
  logic        selected;
  logic        tx;
  logic        irq;

  int errors = 0;
  int checks = 0;

  uart_tx_port dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_strobes (data_strobes),
    .read         (read),
    .write        (write),
    .selected     (selected),
    .tx           (tx),
    .irq          (irq)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic wr(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] s);
    address      = {BASE[31:4], idx};
    data_in      = d;
    data_strobes = s;
    write        = 1'b1;
    @(posedge clock);
    #1;
    write        = 1'b0;
    data_strobes = 4'b0;
  endtask

  task automatic rd(input logic [1:0] idx, output logic [31:0] d);
    address = {BASE[31:4], idx};
    read    = 1'b1;
    #1;
    d       = data_out;
    read    = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rd(2'd1, v);
    checks++; if (v !== 32'h0000_0001) begin errors++; $display("FAIL reset_status: got %h expected %h", v, 32'h1); end
    rd(2'd2, v);
    checks++; if (v !== 32'd433) begin errors++; $display("FAIL reset_divisor: got %h expected %h", v, 32'd433); end
    rd(2'd3, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_control: got %h expected %h", v, 32'h0); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_single_frame();
    logic [7:0]  b;
    logic [31:0] v;
    logic        e;
    int          j;
    b = 8'hA5;
    wr(2'd2, 32'd3, 4'b0011);
    wr(2'd3, 32'd1, 4'b0001);
    wr(2'd0, {24'h0, b}, 4'b0001);
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      j = i / 4;
      if (j == 0)      e = 1'b0;
      else if (j == 9) e = 1'b1;
      else             e = b[j-1];
      checks++; if (tx !== e) begin errors++; $display("FAIL frame_tx[%0d]: got %b expected %b", i, tx, e); end
      if (i == 20) begin
        rd(2'd1, v);
        checks++; if (v[2] !== 1'b1) begin errors++; $display("FAIL frame_busy: got %b expected 1", v[2]); end
      end
    end
    @(posedge clock);
    #1;
    rd(2'd1, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL frame_status_after: got %h expected %h", v, 32'h1); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL frame_tx_after: got %b expected 1", tx); end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    logic [7:0]  got;
    bit          found;
    bit          low;
    wr(2'd3, 32'd0, 4'b0001);
    for (int i = 0; i < 9; i++) wr(2'd0, 32'h10 + i, 4'b0001);
    rd(2'd1, v);
    checks++; if (v !== 32'h80A) begin errors++; $display("FAIL ovf_status: got %h expected %h", v, 32'h80A); end
    wr(2'd1, 32'h8, 4'b0001);
    rd(2'd1, v);
    checks++; if (v !== 32'h802) begin errors++; $display("FAIL ovf_clear: got %h expected %h", v, 32'h802); end
    wr(2'd2, 32'd0, 4'b0011);
    wr(2'd3, 32'd1, 4'b0001);
    for (int n = 0; n < 8; n++) begin
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
        @(posedge clock);
        #1;
        if (tx === 1'b0) found = 1'b1;
      end
      got = 8'h0;
      if (found) begin
        for (int k = 0; k < 8; k++) begin
          @(posedge clock);
          #1;
          got[k] = tx;
        end
      end
      checks++; if (!found || got !== 8'(8'h10 + n)) begin errors++; $display("FAIL ovf_byte[%0d]: got %h expected %h (start seen %0d)", n, got, 8'(8'h10 + n), found); end
    end
    low = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock);
      #1;
      if (tx !== 1'b1) low = 1'b1;
    end
    checks++; if (low !== 1'b0) begin errors++; $display("FAIL ovf_no_ninth: got low expected idle high"); end
    rd(2'd1, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL ovf_drained: got %h expected %h", v, 32'h1); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] v;
    wr(2'd3, 32'd0, 4'b0001);
    wr(2'd2, 32'd3, 4'b0011);
    for (int i = 0; i < 8; i++) wr(2'd0, 32'h40 + i, 4'b0001);
    rd(2'd1, v);
    checks++; if (v !== 32'h802) begin errors++; $display("FAIL full_before: got %h expected %h", v, 32'h802); end
    wr(2'd3, 32'd1, 4'b0001);
    wr(2'd0, 32'h55, 4'b0001);
    rd(2'd1, v);
    checks++; if (v !== 32'h806) begin errors++; $display("FAIL full_push_pop: got %h expected %h", v, 32'h806); end
  endtask

  task automatic test_strobes_decode();
    logic [31:0] v;
    pulse_reset();
    wr(2'd0, 32'h0000_00FF, 4'b1110);
    rd(2'd1, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL strobe_no_push: got %h expected %h", v, 32'h1); end
    address      = 30'((BASE + 32'h10) >> 2);
    data_in      = 32'h77;
    data_strobes = 4'b1111;
    write        = 1'b1;
    #1;
    checks++; if (selected !== 1'b0) begin errors++; $display("FAIL decode_selected: got %b expected 0", selected); end
    @(posedge clock);
    #1;
    write        = 1'b0;
    data_strobes = 4'b0;
    rd(2'd1, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL decode_no_push: got %h expected %h", v, 32'h1); end
    address = 30'((BASE + 32'h14) >> 2);
    read    = 1'b1;
    #1;
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL decode_read_zero: got %h expected %h", data_out, 32'h0); end
    read = 1'b0;
    wr(2'd2, 32'h1234_5678, 4'b0001);
    rd(2'd2, v);
    checks++; if (v !== 32'h0178) begin errors++; $display("FAIL divisor_lane0: got %h expected %h", v, 32'h0178); end
    wr(2'd2, 32'h0000_AB00, 4'b0010);
    rd(2'd2, v);
    checks++; if (v !== 32'hAB78) begin errors++; $display("FAIL divisor_lane1: got %h expected %h", v, 32'hAB78); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    int          k;
    bit          low;
    bit          early;
    pulse_reset();
    wr(2'd2, 32'd3, 4'b0011);
    wr(2'd3, 32'd1, 4'b0001);
    wr(2'd0, 32'hA5, 4'b0001);
    repeat (17) @(posedge clock);
    #1;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_bit3: got %b expected 0", tx); end
    pulse_reset();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_reset_tx: got %b expected 1", tx); end
    rd(2'd1, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL mid_reset_status: got %h expected %h", v, 32'h1); end

    wr(2'd2, 32'd3, 4'b0011);
    wr(2'd3, 32'd1, 4'b0001);
    wr(2'd0, 32'h11, 4'b0001);
    wr(2'd0, 32'h22, 4'b0001);
    wr(2'd0, 32'h33, 4'b0001);
    wr(2'd3, 32'd0, 4'b0001);
    k = 0;
    v = 32'h4;
    while (v[2] !== 1'b0 && k < 100) begin
      @(posedge clock);
      #1;
      k++;
      rd(2'd1, v);
    end
    checks++; if (k !== 38) begin errors++; $display("FAIL disable_finish_cycles: got %0d expected %0d", k, 38); end
    low = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      #1;
      if (tx !== 1'b1) low = 1'b1;
    end
    checks++; if (low !== 1'b0) begin errors++; $display("FAIL disable_tx_idle: got low expected idle high"); end
    rd(2'd1, v);
    checks++; if (v !== 32'h200) begin errors++; $display("FAIL disable_count: got %h expected %h", v, 32'h200); end

    wr(2'd3, 32'd3, 4'b0001);
    early = 1'b0;
    for (int i = 1; i <= 83; i++) begin
      @(posedge clock);
      #1;
      if (i < 82 && irq !== 1'b0) early = 1'b1;
      if (i == 82) begin
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before: got %b expected 0", irq); end
      end
      if (i == 83) begin
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", irq); end
      end
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", early); end
  endtask

  initial begin
    reset        = 1'b1;
    address      = '0;
    data_in      = '0;
    data_strobes = '0;
    read         = 1'b0;
    write        = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    test_reset();
    test_single_frame();
    test_overflow();
    test_push_pop_full();
    test_strobes_decode();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
